// File: rtl/bsg_manycore_ruche_x_pod_link_buffer.sv
// Bidirectional elastic buffer for the horizontal pod boundary: every unmasked
// channel is retimed through a chain of two-entry stages in each direction.

module bsg_manycore_ruche_x_pod_link_buffer_fifo2 #(
    parameter int width_p = 64
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_v,
    input  logic [width_p-1:0] i_data,
    output logic               o_ready,
    output logic               o_v,
    output logic [width_p-1:0] o_data,
    input  logic               i_ready,
    output logic               o_empty
);
    logic [1:0][width_p-1:0] r_mem;
    logic                    r_wptr;
    logic                    r_rptr;
    logic                    r_full;
    logic                    r_empty;
    logic                    w_enq;
    logic                    w_deq;

    // Handshake outputs come from flags only; reset masks them combinationally.
    assign o_ready = ~r_full & ~i_reset;
    assign o_v     = ~r_empty & ~i_reset;
    assign o_data  = r_mem[r_rptr];
    assign o_empty = r_empty;

    assign w_enq = i_v & o_ready;
    assign w_deq = o_v & i_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_enq) r_wptr <= ~r_wptr;
            if (w_deq) r_rptr <= ~r_rptr;
            if (w_enq && !w_deq) begin
                r_empty <= 1'b0;
                r_full  <= ~r_empty;
            end else if (w_deq && !w_enq) begin
                r_full  <= 1'b0;
                r_empty <= ~r_full;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_enq) r_mem[r_wptr] <= i_data;
    end
endmodule

module bsg_manycore_ruche_x_pod_link_buffer_chain #(
    parameter int width_p      = 64,
    parameter int num_stages_p = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_v,
    input  logic [width_p-1:0] i_data,
    output logic               o_ready,
    output logic               o_v,
    output logic [width_p-1:0] o_data,
    input  logic               i_ready,
    output logic               o_empty
);
    logic [num_stages_p:0]              w_v;
    logic [num_stages_p:0]              w_ready;
    logic [num_stages_p:0][width_p-1:0] w_data;
    logic [num_stages_p-1:0]            w_empty;

    assign w_v[0]              = i_v;
    assign w_data[0]           = i_data;
    assign o_ready             = w_ready[0];
    assign o_v                 = w_v[num_stages_p];
    assign o_data              = w_data[num_stages_p];
    assign w_ready[num_stages_p] = i_ready;
    assign o_empty             = &w_empty;

    for (genvar s = 0; s < num_stages_p; s++) begin : g_stage
        bsg_manycore_ruche_x_pod_link_buffer_fifo2 #(
            .width_p(width_p)
        ) u_fifo (
            .i_clk  (i_clk),
            .i_reset(i_reset),
            .i_v    (w_v[s]),
            .i_data (w_data[s]),
            .o_ready(w_ready[s]),
            .o_v    (w_v[s+1]),
            .o_data (w_data[s+1]),
            .i_ready(w_ready[s+1]),
            .o_empty(w_empty[s])
        );
    end
endmodule

module bsg_manycore_ruche_x_pod_link_buffer #(
    parameter int                    width_p       = 64,
    parameter int                    num_rows_p    = 8,
    parameter int                    num_chan_p    = 3,
    parameter int                    num_stages_p  = 2,
    parameter logic [num_chan_p-1:0] tieoff_mask_p = '0,
    localparam int                   n_lp          = num_rows_p * num_chan_p
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [n_lp-1:0]         w_v_i,
    input  logic [n_lp*width_p-1:0] w_data_i,
    output logic [n_lp-1:0]         w_ready_o,
    output logic [n_lp-1:0]         e_v_o,
    output logic [n_lp*width_p-1:0] e_data_o,
    input  logic [n_lp-1:0]         e_ready_i,
    input  logic [n_lp-1:0]         e_v_i,
    input  logic [n_lp*width_p-1:0] e_data_i,
    output logic [n_lp-1:0]         e_ready_o,
    output logic [n_lp-1:0]         w_v_o,
    output logic [n_lp*width_p-1:0] w_data_o,
    input  logic [n_lp-1:0]         w_ready_i,
    output logic                    idle_o
);
    logic [n_lp-1:0] w_idle_east;
    logic [n_lp-1:0] w_idle_west;

    for (genvar i = 0; i < n_lp; i++) begin : g_ch
        localparam int c_lp = i % num_chan_p;
        if (tieoff_mask_p[c_lp]) begin : g_tie
            // Channel does not cross this boundary: sink inputs, drive idle outputs.
            logic w_unused;
            assign w_unused = ^{w_v_i[i], e_v_i[i], e_ready_i[i], w_ready_i[i],
                                w_data_i[i*width_p +: width_p],
                                e_data_i[i*width_p +: width_p]};
            assign w_ready_o[i]                   = 1'b1;
            assign e_ready_o[i]                   = 1'b1;
            assign e_v_o[i]                       = 1'b0;
            assign w_v_o[i]                       = 1'b0;
            assign e_data_o[i*width_p +: width_p] = '0;
            assign w_data_o[i*width_p +: width_p] = '0;
            assign w_idle_east[i]                 = 1'b1;
            assign w_idle_west[i]                 = 1'b1;
        end else begin : g_buf
            bsg_manycore_ruche_x_pod_link_buffer_chain #(
                .width_p     (width_p),
                .num_stages_p(num_stages_p)
            ) u_east (
                .i_clk  (clk_i),
                .i_reset(reset_i),
                .i_v    (w_v_i[i]),
                .i_data (w_data_i[i*width_p +: width_p]),
                .o_ready(w_ready_o[i]),
                .o_v    (e_v_o[i]),
                .o_data (e_data_o[i*width_p +: width_p]),
                .i_ready(e_ready_i[i]),
                .o_empty(w_idle_east[i])
            );
            bsg_manycore_ruche_x_pod_link_buffer_chain #(
                .width_p     (width_p),
                .num_stages_p(num_stages_p)
            ) u_west (
                .i_clk  (clk_i),
                .i_reset(reset_i),
                .i_v    (e_v_i[i]),
                .i_data (e_data_i[i*width_p +: width_p]),
                .o_ready(e_ready_o[i]),
                .o_v    (w_v_o[i]),
                .o_data (w_data_o[i*width_p +: width_p]),
                .i_ready(w_ready_i[i]),
                .o_empty(w_idle_west[i])
            );
        end
    end

    // Empty flags may still be stale on the first reset edge, so reset forces idle.
    assign idle_o = reset_i | ((&w_idle_east) & (&w_idle_west));
endmodule
